// File: rtl/step_shift_unloader_if.sv
// step_shift_unloader_if: load-side valid/ready bus feeding a parallel word into the unloader.
interface step_shift_unloader_if #(
   parameter int WIDTH = 8
);
   logic             ld_valid;
   logic             ld_ready;
   logic [WIDTH-1:0] din;

   modport master (output ld_valid, din, input ld_ready);
   modport slave  (input ld_valid, din, output ld_ready);
endinterface

// File: rtl/step_shift_unloader.sv
// step_shift_unloader: parallel-in, step-gated serial-out unloader.
// Define STEP_UNLOAD_PARITY_EN to append an even-parity bit after the data bits.
module step_shift_unloader #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 step_i,
   step_shift_unloader_if.slave ld,
   output logic                 sout_o,
   output logic                 sout_valid_o,
   output logic                 last_o,
   output logic                 busy_o
);
   localparam int             CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

`ifdef STEP_UNLOAD_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_e;
   logic par_q, par_d;
`else
   typedef enum logic {IDLE, SHIFT} state_e;
`endif

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shifted;
   logic             head;

   // Shift toward whichever end feeds sout, zero-filling the vacated bit.
   assign shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
   assign head    = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
   assign busy_o  = state_q != IDLE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
`ifdef STEP_UNLOAD_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
`ifdef STEP_UNLOAD_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      cnt_d        = cnt_q;
`ifdef STEP_UNLOAD_PARITY_EN
      par_d        = par_q;
`endif
      sout_o       = 1'b0;
      sout_valid_o = 1'b0;
      last_o       = 1'b0;
      ld.ld_ready  = 1'b0;
      case (state_q)
         IDLE: begin
            ld.ld_ready = 1'b1;
            if (ld.ld_valid) begin
               shreg_d = ld.din;
               cnt_d   = '0;
`ifdef STEP_UNLOAD_PARITY_EN
               par_d   = ^ld.din;
`endif
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sout_o       = head;
            sout_valid_o = 1'b1;
`ifndef STEP_UNLOAD_PARITY_EN
            last_o       = cnt_q == LAST_CNT;
`endif
            if (step_i) begin
               shreg_d = shifted;
               // Counter never passes WIDTH-1: the final step clears it instead.
               cnt_d   = (cnt_q == LAST_CNT) ? '0 : cnt_q + CW'(1);
`ifdef STEP_UNLOAD_PARITY_EN
               if (cnt_q == LAST_CNT) state_d = PAR;
`else
               if (cnt_q == LAST_CNT) state_d = IDLE;
`endif
            end
         end
`ifdef STEP_UNLOAD_PARITY_EN
         PAR: begin
            sout_o       = par_q;
            sout_valid_o = 1'b1;
            last_o       = 1'b1;
            if (step_i) state_d = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_step_shift_unloader.sv
// tb_step_shift_unloader: MSB-first and LSB-first unloaders driven in lockstep, checked
// against a bit-queue frame model plus directed scenarios.
module tb_step_shift_unloader;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         step = 1'b0;
   logic         ld_valid = 1'b0;
   logic [W-1:0] din = '0;
   logic         sout_m, vld_m, last_m, busy_m;
   logic         sout_l, vld_l, last_l, busy_l;
   logic         chk = 1'b0;
   int           vec = 0;
   int           errs = 0;
   bit           qm[$];
   bit           ql[$];

   step_shift_unloader_if #(.WIDTH(W)) if_m ();
   step_shift_unloader_if #(.WIDTH(W)) if_l ();
   assign if_m.ld_valid = ld_valid;
   assign if_m.din      = din;
   assign if_l.ld_valid = ld_valid;
   assign if_l.din      = din;

   step_shift_unloader #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst_n(rst_n), .step_i(step), .ld(if_m.slave),
      .sout_o(sout_m), .sout_valid_o(vld_m), .last_o(last_m), .busy_o(busy_m));
   step_shift_unloader #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst_n(rst_n), .step_i(step), .ld(if_l.slave),
      .sout_o(sout_l), .sout_valid_o(vld_l), .last_o(last_l), .busy_o(busy_l));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // A frame is just the list of bits still to be emitted; busy means the list is non-empty.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qm.delete();
         ql.delete();
      end else if (qm.size() == 0) begin
         if (ld_valid) begin
            for (int i = 0; i < W; i++) begin
               qm.push_back(din[W-1-i]);
               ql.push_back(din[i]);
            end
`ifdef STEP_UNLOAD_PARITY_EN
            qm.push_back(^din);
            ql.push_back(^din);
`endif
         end
      end else if (step) begin
         void'(qm.pop_front());
         void'(ql.pop_front());
      end
   end

   // {sout, sout_valid, last, busy, ld_ready}
   function automatic logic [4:0] expv(input bit q[$]);
      return (q.size() != 0) ? {q[0], 1'b1, q.size() == 1, 1'b1, 1'b0} : 5'b00001;
   endfunction

   always @(negedge clk) begin
      if (chk) begin
         check("model_msb", {sout_m, vld_m, last_m, busy_m, if_m.ld_ready}, expv(qm));
         check("model_lsb", {sout_l, vld_l, last_l, busy_l, if_l.ld_ready}, expv(ql));
      end
   end

   task automatic tick(input logic v, input logic [W-1:0] d, input logic s);
      @(negedge clk);
      #1;
      ld_valid = v;
      din      = d;
      step     = s;
   endtask

   initial begin
      logic [W-1:0] w;
      ld_valid = 1'b1;
      step     = 1'b1;
      din      = 8'hFF;
      @(posedge clk);
      chk = 1'b1;
      repeat (3) tick(1'b1, W'($urandom), 1'b1);
      check("rst_hold", {sout_m, vld_m, last_m, busy_m, if_m.ld_ready}, 5'b00001);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      ld_valid = 1'b0;
      step = 1'b0;

      // A5 MSB-first, stepping every third clock
      w = 8'hA5;
      tick(1'b1, w, 1'b0);
      for (int i = 0; i < W; i++) begin
         tick(1'b0, '0, 1'b0);
         tick(1'b0, '0, 1'b0);
         tick(1'b0, '0, 1'b1);
         check("a5_bit", sout_m, w[W-1-i]);
`ifdef STEP_UNLOAD_PARITY_EN
         check("a5_last", last_m, 1'b0);
`else
         check("a5_last", last_m, i == W - 1);
`endif
      end
`ifdef STEP_UNLOAD_PARITY_EN
      tick(1'b0, '0, 1'b1);
      check("a5_par", {sout_m, last_m}, {^w, 1'b1});
`endif
      tick(1'b0, '0, 1'b0);
      check("a5_ready", if_m.ld_ready, 1'b1);

      // 01 LSB-first with step held high; load wins over the coincident step
      tick(1'b1, 8'h01, 1'b1);
      for (int i = 0; i < W; i++) begin
         tick(1'b0, '0, 1'b1);
         check("01_bit", sout_l, i == 0);
      end
`ifdef STEP_UNLOAD_PARITY_EN
      tick(1'b0, '0, 1'b1);
      check("01_par", sout_l, 1'b1);
`endif
      tick(1'b0, '0, 1'b0);
      check("01_busy", busy_l, 1'b0);

      // load attempt mid-frame is ignored
      w = W'($urandom);
      tick(1'b1, w, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, W'($urandom), 1'b1);
         check("ign_bit", sout_m, w[W-1-i]);
      end
      tick(1'b1, 8'hFF, 1'b0);
      for (int i = 3; i < W; i++) begin
         tick(1'b0, W'($urandom), 1'b1);
         check("ign_bit", sout_m, w[W-1-i]);
         check("ign_bit_l", sout_l, w[i]);
      end
`ifdef STEP_UNLOAD_PARITY_EN
      tick(1'b0, '0, 1'b1);
`endif
      tick(1'b0, '0, 1'b0);

      // reset mid-frame, then a clean 3C frame
      tick(1'b1, W'($urandom), 1'b0);
      repeat (4) tick(1'b0, '0, 1'b1);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_mid_m", {sout_m, vld_m, last_m, busy_m, if_m.ld_ready}, 5'b00001);
      check("rst_mid_l", {sout_l, vld_l, last_l, busy_l, if_l.ld_ready}, 5'b00001);
      tick(1'b1, W'($urandom), 1'b1);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      w = 8'h3C;
      ld_valid = 1'b1;
      din = w;
      step = 1'b0;
      for (int i = 0; i < W; i++) begin
         tick(1'b0, '0, 1'b1);
         check("3c_bit", sout_m, w[W-1-i]);
         check("3c_bit_l", sout_l, w[i]);
      end
`ifdef STEP_UNLOAD_PARITY_EN
      tick(1'b0, '0, 1'b1);
      check("3c_par", sout_m, 1'b0);
      // 07 and 03: parity bits 1 and 0
      w = 8'h07;
      tick(1'b1, w, 1'b0);
      repeat (W) tick(1'b0, '0, 1'b1);
      tick(1'b0, '0, 1'b0);
      check("07_par", {sout_m, vld_m, last_m}, 3'b111);
      w = 8'h03;
      tick(1'b0, '0, 1'b1);
      tick(1'b1, w, 1'b0);
      repeat (W) tick(1'b0, '0, 1'b1);
      tick(1'b0, '0, 1'b0);
      check("03_par", {sout_m, vld_m, last_m}, 3'b011);
      tick(1'b0, '0, 1'b1);
`endif
      tick(1'b0, '0, 1'b0);

      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         #1;
         rst_n    = $urandom_range(199) != 0;
         ld_valid = $urandom_range(1) == 1;
         din      = W'($urandom);
         step     = $urandom_range(4) < 2;
      end
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) tick(1'b0, '0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
